pwm_update_scheduler: RTL and testbench

- Sequences parameter updates into a bank of pwm_generator instances, one per transducer.
- Accepts a stream of per-channel (pulse width, phase) pairs and converts each to 8-bit rise/fall edges.
- Stages results in a shadow bank, then commits the whole bank at a PWM period boundary, so no generator sees a torn or mid-period edge change.
- Sits between the modulation/STM datapath and the pwm_generator array; shares TIME_CNT with them.

---
 rtl/pwm_sched_pkg.sv | 16 +
 rtl/pwm_update_scheduler_if.sv | 10 +
 rtl/pwm_edge_calc.sv | 40 ++++
 rtl/pwm_update_scheduler.sv | 112 +++++++++++
 tb/tb_pwm_update_scheduler.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pwm_sched_pkg.sv
// Shared types and constants for the PWM update scheduler.
// Edge arithmetic is 8-bit because the PWM period is fixed at 256 ticks.
package pwm_sched_pkg;
  localparam int T = 256;

  typedef logic [$clog2(T)-1:0] edge_t;

  localparam edge_t CNT_LAST = 8'd255;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DRAIN,
    PENDING
  } state_t;
endpackage

// File: rtl/pwm_update_scheduler_if.sv
// Parameter stream from the modulation datapath: one (pulse width, phase) pair per channel.
interface pwm_update_scheduler_if;
  logic       DIN_VALID;
  logic       DIN_READY;
  logic [7:0] PULSE_WIDTH;
  logic [7:0] PHASE;

  modport master (output DIN_VALID, PULSE_WIDTH, PHASE, input DIN_READY);
  modport slave  (input DIN_VALID, PULSE_WIDTH, PHASE, output DIN_READY);
endinterface

// File: rtl/pwm_edge_calc.sv
// Registered conversion of (pulse width, phase) into centred rise/fall edges, mod 256.
module pwm_edge_calc
  import pwm_sched_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic       EN,
  input  logic [7:0] PULSE_WIDTH,
  input  logic [7:0] PHASE,
  output edge_t      RISE,
  output edge_t      FALL
);
  edge_t half;
  edge_t rise_d, rise_q;
  edge_t fall_d, fall_q;

  // Odd widths put the extra tick after the centre, so fall - rise == width exactly.
  always_comb begin
    half   = PULSE_WIDTH >> 1;
    rise_d = rise_q;
    fall_d = fall_q;
    if (EN) begin
      rise_d = PHASE - half;
      fall_d = PHASE + PULSE_WIDTH - half;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign RISE = rise_q;
  assign FALL = fall_q;
endmodule

// File: rtl/pwm_update_scheduler.sv
// Loads a shadow bank of per-channel PWM edges and commits the whole bank atomically
// on the TIME_CNT 255 -> 0 boundary, so generators never see a torn period.
module pwm_update_scheduler
  import pwm_sched_pkg::*;
#(
  parameter int DEPTH = 249
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [7:0]               TIME_CNT,
  pwm_update_scheduler_if.slave    din,
  output edge_t [DEPTH-1:0]        RISE,
  output edge_t [DEPTH-1:0]        FALL,
  output logic                     UPDATE_DONE,
  output logic                     BUSY
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] s1_idx_q, s1_idx_d;
  logic s1_vld_q, s1_vld_d;
  logic done_q, done_d;
  edge_t s1_rise, s1_fall;
  edge_t [DEPTH-1:0] shd_rise_q, shd_rise_d, shd_fall_q, shd_fall_d;
  edge_t [DEPTH-1:0] act_rise_q, act_rise_d, act_fall_q, act_fall_d;

  logic xfer, last_ch, commit;

  assign xfer    = din.DIN_VALID && din.DIN_READY;
  assign last_ch = (idx_q == IDX_W'(DEPTH - 1));

  pwm_edge_calc u_calc (
    .CLK        (CLK),
    .RST        (RST),
    .EN         (xfer),
    .PULSE_WIDTH(din.PULSE_WIDTH),
    .PHASE      (din.PHASE),
    .RISE       (s1_rise),
    .FALL       (s1_fall)
  );

  // Next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (xfer) state_d = (DEPTH == 1) ? DRAIN : LOAD;
      LOAD:    if (xfer && last_ch) state_d = DRAIN;
      DRAIN:   state_d = PENDING;
      PENDING: if (commit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs; ready is held low while reset is asserted.
  always_comb begin
    din.DIN_READY = ((state_q == IDLE) || (state_q == LOAD)) && !RST;
    BUSY          = (state_q != IDLE);
    commit        = (state_q == PENDING) && (TIME_CNT == CNT_LAST);
  end

  // Datapath: stage-1 result lands in the shadow bank one edge after acceptance.
  always_comb begin
    idx_d      = idx_q;
    s1_vld_d   = xfer;
    s1_idx_d   = s1_idx_q;
    shd_rise_d = shd_rise_q;
    shd_fall_d = shd_fall_q;
    act_rise_d = act_rise_q;
    act_fall_d = act_fall_q;
    done_d     = commit;
    if (commit) idx_d = '0;
    else if (xfer) idx_d = idx_q + 1'b1;
    if (xfer) s1_idx_d = idx_q;
    if (s1_vld_q) begin
      shd_rise_d[s1_idx_q] = s1_rise;
      shd_fall_d[s1_idx_q] = s1_fall;
    end
    if (commit) begin
      act_rise_d = shd_rise_q;
      act_fall_d = shd_fall_q;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      s1_vld_q   <= 1'b0;
      s1_idx_q   <= '0;
      shd_rise_q <= '0;
      shd_fall_q <= '0;
      act_rise_q <= '0;
      act_fall_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      s1_vld_q   <= s1_vld_d;
      s1_idx_q   <= s1_idx_d;
      shd_rise_q <= shd_rise_d;
      shd_fall_q <= shd_fall_d;
      act_rise_q <= act_rise_d;
      act_fall_q <= act_fall_d;
      done_q     <= done_d;
    end
  end

  assign RISE        = act_rise_q;
  assign FALL        = act_fall_q;
  assign UPDATE_DONE = done_q;
endmodule

// File: tb/tb_pwm_update_scheduler.sv
// Bench for pwm_update_scheduler: table vectors plus a commit scoreboard and timing corners.
module tb_pwm_update_scheduler;
  localparam int DEPTH = 8;

  typedef struct {
    logic [7:0] pw;
    logic [7:0] ph;
    logic [7:0] er;
    logic [7:0] ef;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] tcnt = 8'd0;
  logic [DEPTH-1:0][7:0] rise, fall;
  logic upd, busy;
  logic [DEPTH-1:0][7:0] act_r, act_f;
  logic [15:0] sb_q[$];
  vec_t tbl[DEPTH];
  vec_t tbl0[DEPTH];
  int n_tests = 0;
  int n_fail = 0;
  int hold_bad = 0;
  logic [7:0] last_t;

  pwm_update_scheduler_if bus();

  pwm_update_scheduler #(.DEPTH(DEPTH)) dut (
    .CLK        (clk),
    .RST        (rst),
    .TIME_CNT   (tcnt),
    .din        (bus),
    .RISE       (rise),
    .FALL       (fall),
    .UPDATE_DONE(upd),
    .BUSY       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) tcnt <= tcnt + 8'd1;

  task automatic chk(input string nm, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    end
  endtask

  // Active bank must not move except on an UPDATE_DONE cycle.
  task automatic tick();
    @(posedge clk);
    #1;
    if (!rst && !upd && (rise !== act_r || fall !== act_f)) hold_bad++;
  endtask

  function automatic logic [15:0] ref_edges(input int pw, input int ph);
    int r, f;
    r = (ph + 256 - pw / 2) % 256;
    f = (r + pw) % 256;
    return {8'(r), 8'(f)};
  endfunction

  function automatic int duty(input logic [7:0] r, input logic [7:0] f);
    int d = 0;
    for (int t = 0; t < 256; t++)
      if ((r <= f) ? (t >= r && t < f) : (t >= r || t < f)) d++;
    return d;
  endfunction

  // First edge at least two after the transfer that samples TIME_CNT == 255.
  function automatic int exp_lat(input int x);
    for (int n = 2; n < 600; n++)
      if ((x + n) % 256 == 255) return n;
    return -1;
  endfunction

  task automatic fill_random();
    logic [15:0] e;
    for (int i = 0; i < DEPTH; i++) begin
      tbl[i].pw = 8'($urandom_range(0, 255));
      tbl[i].ph = 8'($urandom_range(0, 255));
      e = ref_edges(int'(tbl[i].pw), int'(tbl[i].ph));
      tbl[i].er = e[15:8];
      tbl[i].ef = e[7:0];
    end
  endtask

  task automatic send(input vec_t v, output logic [7:0] t_at);
    int n = 0;
    logic acc = 1'b0;
    t_at = 8'd0;
    bus.DIN_VALID   = 1'b1;
    bus.PULSE_WIDTH = v.pw;
    bus.PHASE       = v.ph;
    while (!acc && n < 50) begin
      acc  = bus.DIN_READY;
      t_at = tcnt;
      tick();
      n++;
    end
    bus.DIN_VALID = 1'b0;
    if (!acc) chk("send_timeout", 1, 0);
    else sb_q.push_back({v.er, v.ef});
  endtask

  task automatic load(input bit gaps, input int last_at, input int upto);
    logic [7:0] t;
    for (int i = 0; i < upto; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) tick();
      if (i == DEPTH - 1 && last_at >= 0) begin
        int n = 0;
        while (int'(tcnt) != last_at && n < 300) begin
          tick();
          n++;
        end
      end
      send(tbl[i], t);
      last_t = t;
    end
  endtask

  task automatic wait_commit(input int lat, input string nm);
    int n = 0;
    logic [15:0] e;
    while (!upd && n < 600) begin
      tick();
      n++;
    end
    if (!upd) begin
      chk({nm, "_timeout"}, 1, 0);
      return;
    end
    if (lat >= 0) chk({nm, "_latency"}, n, lat);
    chk({nm, "_tcnt_at_done"}, int'(tcnt), 0);
    chk({nm, "_sb_size"}, sb_q.size(), DEPTH);
    for (int i = 0; i < DEPTH; i++) begin
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        act_r[i] = e[15:8];
        act_f[i] = e[7:0];
        chk($sformatf("%s_rise%0d", nm, i), int'(rise[i]), int'(e[15:8]));
        chk($sformatf("%s_fall%0d", nm, i), int'(fall[i]), int'(e[7:0]));
      end
    end
    tick();
    chk({nm, "_done_pulse"}, int'(upd), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.DIN_VALID = 1'b0;
    #1;
    chk("rst_rise_zero", int'(|rise), 0);
    chk("rst_fall_zero", int'(|fall), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ready", int'(bus.DIN_READY), 0);
    chk("rst_done", int'(upd), 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready_held", int'(bus.DIN_READY), 0);
    rst = 1'b0;
    sb_q.delete();
    act_r = '0;
    act_f = '0;
    #1;
    chk("post_rst_ready", int'(bus.DIN_READY), 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int xs[4];
    bus.DIN_VALID   = 1'b0;
    bus.PULSE_WIDTH = 8'd0;
    bus.PHASE       = 8'd0;
    act_r = '0;
    act_f = '0;
    tbl0[0] = '{8'd128, 8'd0,   8'd192, 8'd64};
    tbl0[1] = '{8'd0,   8'd200, 8'd200, 8'd200};
    tbl0[2] = '{8'd255, 8'd10,  8'd139, 8'd138};
    tbl0[3] = '{8'd128, 8'd128, 8'd64,  8'd192};
    tbl0[4] = '{8'd1,   8'd0,   8'd0,   8'd1};
    tbl0[5] = '{8'd2,   8'd255, 8'd254, 8'd0};
    tbl0[6] = '{8'd200, 8'd50,  8'd206, 8'd150};
    tbl0[7] = '{8'd7,   8'd100, 8'd97,  8'd104};

    @(posedge clk);
    #1;
    do_reset();

    // Hand-computed vectors, back-to-back, then generator duty on the committed bank.
    tbl = tbl0;
    load(1'b0, -1, DEPTH);
    chk("ready_after_last", int'(bus.DIN_READY), 0);
    chk("busy_after_last", int'(busy), 1);
    wait_commit(-1, "tbl");
    for (int i = 0; i < DEPTH; i++)
      chk($sformatf("duty%0d", i), duty(rise[i], fall[i]), int'(tbl0[i].pw));

    // Uniform bank; previous bank must hold while it loads.
    for (int i = 0; i < DEPTH; i++) tbl[i] = '{8'd128, 8'd128, 8'd64, 8'd192};
    load(1'b0, -1, DEPTH);
    wait_commit(-1, "uni");

    // Last transfer around the period boundary.
    xs = '{253, 254, 255, 0};
    for (int k = 0; k < 4; k++) begin
      fill_random();
      load(1'b0, xs[k], DEPTH);
      chk($sformatf("last_tcnt_%0d", xs[k]), int'(last_t), xs[k]);
      wait_commit(exp_lat(xs[k]), $sformatf("edge%0d", xs[k]));
    end

    // Random valid gaps while loading.
    repeat (2) begin
      fill_random();
      load(1'b1, -1, DEPTH);
      wait_commit(-1, "gaps");
    end

    // Reset halfway through a load, then a clean reload from channel 0.
    fill_random();
    load(1'b0, -1, DEPTH / 2);
    chk("midload_busy", int'(busy), 1);
    do_reset();
    tbl = tbl0;
    load(1'b0, -1, DEPTH);
    wait_commit(-1, "after_rst_load");

    // Reset while waiting for the boundary.
    fill_random();
    load(1'b0, 100, DEPTH);
    tick();
    tick();
    chk("pending_busy", int'(busy), 1);
    chk("pending_no_commit", int'(upd), 0);
    do_reset();
    fill_random();
    load(1'b1, -1, DEPTH);
    wait_commit(-1, "after_rst_pend");

    chk("active_bank_hold", hold_bad, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
